// File: rtl/bus_master_pkg.sv
// Shared register-bus definitions: field widths and offsets, the default
// timeout that all bridges agree on, the master FSM states and a helper
// that assembles the bus_in vector from its fields.
package bus_master_pkg;

    localparam int BUS_ADDR_WIDTH = 16;
    localparam int BUS_DATA_WIDTH = 32;

    // bus_in field offsets (master -> slaves)
    localparam int BUS_FIELD_CLK     = 0;
    localparam int BUS_FIELD_RESET_L = 1;
    localparam int BUS_FIELD_REQ     = 2;
    localparam int BUS_FIELD_RD_WR_L = 3;
    localparam int BUS_FIELD_ADDR    = 4;
    localparam int BUS_FIELD_WR_DATA = BUS_FIELD_ADDR + BUS_ADDR_WIDTH;
    localparam int BUS_IN_WIDTH      = BUS_FIELD_WR_DATA + BUS_DATA_WIDTH;

    // bus_out field offsets (OR of all slave returns -> master)
    localparam int BUS_FIELD_DATA = 0;
    localparam int BUS_FIELD_ACK  = BUS_DATA_WIDTH;
    localparam int BUS_OUT_WIDTH  = BUS_DATA_WIDTH + 1;

    // Default number of WAIT cycles before a transaction is declared dead
    localparam int BUS_TIMEOUT_DEFAULT = 256;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2
    } bus_state_t;

    function automatic logic [BUS_IN_WIDTH-1:0] bus_in_pack(
        input logic                      clk,
        input logic                      reset_l,
        input logic                      req,
        input logic                      rd_wr_l,
        input logic [BUS_ADDR_WIDTH-1:0] addr,
        input logic [BUS_DATA_WIDTH-1:0] wr_data
    );
        logic [BUS_IN_WIDTH-1:0] v;
        v                                        = '0;
        v[BUS_FIELD_CLK]                         = clk;
        v[BUS_FIELD_RESET_L]                     = reset_l;
        v[BUS_FIELD_REQ]                         = req;
        v[BUS_FIELD_RD_WR_L]                     = rd_wr_l;
        v[BUS_FIELD_ADDR +: BUS_ADDR_WIDTH]      = addr;
        v[BUS_FIELD_WR_DATA +: BUS_DATA_WIDTH]   = wr_data;
        return v;
    endfunction

endpackage

// File: rtl/bus_master_if.sv
// Host-side handshake plus the register bus itself, bundled for the bus
// master. The master modport is the bus_master view; the slave modport is
// the view of the host bridge and bus slaves around it.
interface bus_master_if;
    import bus_master_pkg::*;

    logic [BUS_IN_WIDTH-1:0]   bus_in;
    logic [BUS_OUT_WIDTH-1:0]  bus_out;
    logic                      host_req;
    logic                      host_rd_wr_l;
    logic [BUS_ADDR_WIDTH-1:0] host_addr;
    logic [BUS_DATA_WIDTH-1:0] host_wr_data;
    logic                      host_ready;
    logic                      host_done;
    logic                      host_err;
    logic [BUS_DATA_WIDTH-1:0] host_rd_data;
    logic                      late_ack;

    modport master (
        output bus_in,
        input  bus_out,
        input  host_req,
        input  host_rd_wr_l,
        input  host_addr,
        input  host_wr_data,
        output host_ready,
        output host_done,
        output host_err,
        output host_rd_data,
        output late_ack
    );

    modport slave (
        input  bus_in,
        output bus_out,
        output host_req,
        output host_rd_wr_l,
        output host_addr,
        output host_wr_data,
        input  host_ready,
        input  host_done,
        input  host_err,
        input  host_rd_data,
        input  late_ack
    );

endinterface

// File: rtl/bus_master.sv
// Single master of the register bus. Takes one host transaction at a time,
// issues a one-cycle bus request, waits for the OR-combined ack and returns
// a completion (with read data) or a timeout to the host. Acks that arrive
// outside WAIT are flagged on late_ack and otherwise ignored.
module bus_master
    import bus_master_pkg::*;
#(
    parameter int unsigned TIMEOUT  = BUS_TIMEOUT_DEFAULT,
    parameter logic [31:0] ERR_DATA = 32'hDEAD_BEEF
) (
    input  logic         bus_clk,
    input  logic         bus_reset_l,
    bus_master_if.master bus
);

    // WAIT exits at TIMEOUT-1, so the counter never needs to wrap
    localparam int                       CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0]         CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [BUS_DATA_WIDTH-1:0] ERR_WORD = BUS_DATA_WIDTH'(ERR_DATA);

    bus_state_t                state,      state_nxt;
    logic                      req_q,      req_nxt;
    logic                      rd_wr_l_q,  rd_wr_l_nxt;
    logic [BUS_ADDR_WIDTH-1:0] addr_q,     addr_nxt;
    logic [BUS_DATA_WIDTH-1:0] wr_data_q,  wr_data_nxt;
    logic                      ready_q,    ready_nxt;
    logic                      done_q,     done_nxt;
    logic                      err_q,      err_nxt;
    logic [BUS_DATA_WIDTH-1:0] rd_data_q,  rd_data_nxt;
    logic                      late_q,     late_nxt;
    logic [CNT_W-1:0]          cnt_q,      cnt_nxt;

    logic                      ack;
    logic [BUS_DATA_WIDTH-1:0] ack_data;

    assign ack      = bus.bus_out[BUS_FIELD_ACK];
    assign ack_data = bus.bus_out[BUS_FIELD_DATA +: BUS_DATA_WIDTH];

    // Clock and reset are forwarded combinationally; all other fields are registered
    assign bus.bus_in = bus_in_pack(bus_clk, bus_reset_l, req_q, rd_wr_l_q,
                                    addr_q, wr_data_q);

    assign bus.host_ready   = ready_q;
    assign bus.host_done    = done_q;
    assign bus.host_err     = err_q;
    assign bus.host_rd_data = rd_data_q;
    assign bus.late_ack     = late_q;

    // State and output registers; reset aborts any transaction in flight
    always_ff @(posedge bus_clk or negedge bus_reset_l) begin
        if (!bus_reset_l) begin
            state     <= ST_IDLE;
            req_q     <= 1'b0;
            rd_wr_l_q <= 1'b1;
            addr_q    <= '0;
            wr_data_q <= '0;
            ready_q   <= 1'b1;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
            rd_data_q <= '0;
            late_q    <= 1'b0;
            cnt_q     <= '0;
        end else begin
            state     <= state_nxt;
            req_q     <= req_nxt;
            rd_wr_l_q <= rd_wr_l_nxt;
            addr_q    <= addr_nxt;
            wr_data_q <= wr_data_nxt;
            ready_q   <= ready_nxt;
            done_q    <= done_nxt;
            err_q     <= err_nxt;
            rd_data_q <= rd_data_nxt;
            late_q    <= late_nxt;
            cnt_q     <= cnt_nxt;
        end
    end

    // Next-state and next-output logic for IDLE -> REQ -> WAIT -> IDLE
    always_comb begin
        state_nxt   = state;
        req_nxt     = 1'b0;
        rd_wr_l_nxt = rd_wr_l_q;
        addr_nxt    = addr_q;
        wr_data_nxt = wr_data_q;
        ready_nxt   = ready_q;
        done_nxt    = 1'b0;
        err_nxt     = err_q;
        rd_data_nxt = rd_data_q;
        late_nxt    = ack && (state != ST_WAIT);
        cnt_nxt     = cnt_q;

        unique case (state)
            ST_IDLE: begin
                // host_ready is always high here, so host_req alone accepts
                if (bus.host_req) begin
                    rd_wr_l_nxt = bus.host_rd_wr_l;
                    addr_nxt    = bus.host_addr;
                    wr_data_nxt = bus.host_wr_data;
                    req_nxt     = 1'b1;
                    ready_nxt   = 1'b0;
                    state_nxt   = ST_REQ;
                end
            end

            ST_REQ: begin
                cnt_nxt   = '0;
                state_nxt = ST_WAIT;
            end

            ST_WAIT: begin
                // An ack on the last WAIT edge still counts as success
                if (ack) begin
                    if (rd_wr_l_q) begin
                        rd_data_nxt = ack_data;
                    end
                    err_nxt   = 1'b0;
                    done_nxt  = 1'b1;
                    ready_nxt = 1'b1;
                    state_nxt = ST_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    if (rd_wr_l_q) begin
                        rd_data_nxt = ERR_WORD;
                    end
                    err_nxt   = 1'b1;
                    done_nxt  = 1'b1;
                    ready_nxt = 1'b1;
                    state_nxt = ST_IDLE;
                end else begin
                    cnt_nxt = cnt_q + CNT_W'(1);
                end
            end

            default: begin
                state_nxt = ST_IDLE;
                ready_nxt = 1'b1;
            end
        endcase
    end

endmodule

// File: tb/tb_bus_master.sv
// Bench for bus_master with TIMEOUT=8. A small slave model answers at
// 0x10 (register, 1-cycle ack), 0x20 (ack on the 8th WAIT edge) and 0x24
// (ack one edge too late); everything else never acks. Expected completions
// are queued when a transaction is driven and compared on host_done.
module tb_bus_master;
    import bus_master_pkg::*;

    localparam int unsigned TB_TIMEOUT = 8;

    typedef struct packed {
        logic                      err;
        logic [BUS_DATA_WIDTH-1:0] data;
    } exp_t;

    logic bus_clk     = 1'b0;
    logic bus_reset_l = 1'b0;

    bus_master_if bif ();

    bus_master #(
        .TIMEOUT  (TB_TIMEOUT),
        .ERR_DATA (32'hDEAD_BEEF)
    ) dut (
        .bus_clk     (bus_clk),
        .bus_reset_l (bus_reset_l),
        .bus         (bif.master)
    );

    always #5 bus_clk = ~bus_clk;

    int   n_checks = 0;
    int   n_errors = 0;
    int   done_cnt = 0;
    int   late_cnt = 0;
    int   exp_done = 0;
    exp_t sb_q[$];
    exp_t mon_e;
    logic [BUS_DATA_WIDTH-1:0] model_rd;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // ---------------- slave model ----------------
    logic                      slv_rst_l;
    logic                      slv_req;
    logic                      slv_rd;
    logic [BUS_ADDR_WIDTH-1:0] slv_bus_addr;
    logic [BUS_DATA_WIDTH-1:0] slv_bus_wd;
    logic                      slv_ack = 1'b0;
    logic [BUS_DATA_WIDTH-1:0] slv_data = '0;
    logic [BUS_ADDR_WIDTH-1:0] slv_addr = '0;
    int                        slv_cnt = 0;
    logic [BUS_DATA_WIDTH-1:0] bus_reg = 32'h1234_5678;

    assign slv_rst_l    = bif.bus_in[BUS_FIELD_RESET_L];
    assign slv_req      = bif.bus_in[BUS_FIELD_REQ];
    assign slv_rd       = bif.bus_in[BUS_FIELD_RD_WR_L];
    assign slv_bus_addr = bif.bus_in[BUS_FIELD_ADDR +: BUS_ADDR_WIDTH];
    assign slv_bus_wd   = bif.bus_in[BUS_FIELD_WR_DATA +: BUS_DATA_WIDTH];
    assign bif.bus_out  = {slv_ack, (slv_ack ? slv_data : {BUS_DATA_WIDTH{1'b0}})};

    function automatic int slv_delay(input logic [BUS_ADDR_WIDTH-1:0] a);
        case (a)
            16'h0010: return 1;
            16'h0020: return 8;
            16'h0024: return 9;
            default:  return 0;
        endcase
    endfunction

    function automatic logic [BUS_DATA_WIDTH-1:0] slv_rdata(input logic [BUS_ADDR_WIDTH-1:0] a,
                                                           input logic [BUS_DATA_WIDTH-1:0] r);
        case (a)
            16'h0010: return r;
            16'h0020: return 32'hCAFE_0020;
            16'h0024: return 32'hCAFE_0024;
            default:  return '0;
        endcase
    endfunction

    // Slave: 0x10 answers one cycle after req and holds a writable register
    always @(posedge bus_clk or negedge slv_rst_l) begin
        if (!slv_rst_l) begin
            slv_ack <= 1'b0;
            slv_cnt <= 0;
        end else begin
            slv_ack <= 1'b0;
            if (slv_req) begin
                slv_addr <= slv_bus_addr;
                if (slv_delay(slv_bus_addr) == 1) begin
                    slv_ack  <= 1'b1;
                    slv_data <= slv_rdata(slv_bus_addr, bus_reg);
                    if (!slv_rd && slv_bus_addr == 16'h0010) bus_reg <= slv_bus_wd;
                end else if (slv_delay(slv_bus_addr) > 1) begin
                    slv_cnt <= slv_delay(slv_bus_addr) - 1;
                end
            end else if (slv_cnt == 1) begin
                slv_ack  <= 1'b1;
                slv_data <= slv_rdata(slv_addr, bus_reg);
                slv_cnt  <= 0;
            end else if (slv_cnt > 1) begin
                slv_cnt <= slv_cnt - 1;
            end
        end
    end

    // Completion monitor: pop the scoreboard on every host_done
    always @(negedge bus_clk) begin
        if (bif.late_ack) late_cnt++;
        if (bif.host_done) begin
            done_cnt++;
            if (sb_q.size() == 0) begin
                chk("unexpected_done", 1, 0);
            end else begin
                mon_e = sb_q.pop_front();
                chk("sb_err", {63'd0, bif.host_err}, {63'd0, mon_e.err});
                chk("sb_rd_data", {32'd0, bif.host_rd_data}, {32'd0, mon_e.data});
            end
        end
    end

    // One host transaction, started at a negedge with the master idle
    task automatic txn(input logic rd, input logic [BUS_ADDR_WIDTH-1:0] a,
                       input logic [BUS_DATA_WIDTH-1:0] wd, input logic exp_err,
                       input logic [BUS_DATA_WIDTH-1:0] exp_data, input int exp_lat,
                       input logic exp_late);
        int k;
        chk("ready_before", {63'd0, bif.host_ready}, 64'd1);
        bif.host_req     = 1'b1;
        bif.host_rd_wr_l = rd;
        bif.host_addr    = a;
        bif.host_wr_data = wd;
        sb_q.push_back('{err: exp_err, data: exp_data});
        exp_done++;
        @(negedge bus_clk);
        bif.host_req = 1'b0;
        chk("req_high", {63'd0, bif.bus_in[BUS_FIELD_REQ]}, 64'd1);
        chk("ready_busy", {63'd0, bif.host_ready}, 64'd0);
        chk("bus_addr", {48'd0, bif.bus_in[BUS_FIELD_ADDR +: BUS_ADDR_WIDTH]}, {48'd0, a});
        chk("bus_rd_wr_l", {63'd0, bif.bus_in[BUS_FIELD_RD_WR_L]}, {63'd0, rd});
        chk("bus_wr_data", {32'd0, bif.bus_in[BUS_FIELD_WR_DATA +: BUS_DATA_WIDTH]}, {32'd0, wd});
        k = 0;
        while (!bif.host_done && k < 40) begin
            @(negedge bus_clk);
            k++;
            if (!bif.host_done) begin
                chk("req_low", {63'd0, bif.bus_in[BUS_FIELD_REQ]}, 64'd0);
                chk("addr_hold", {48'd0, bif.bus_in[BUS_FIELD_ADDR +: BUS_ADDR_WIDTH]}, {48'd0, a});
                chk("ready_wait", {63'd0, bif.host_ready}, 64'd0);
            end
        end
        chk("latency", 64'(k), 64'(exp_lat));
        chk("ready_at_done", {63'd0, bif.host_ready}, 64'd1);
        @(negedge bus_clk);
        chk("late_ack", {63'd0, bif.late_ack}, {63'd0, exp_late});
        chk("done_one_cycle", {63'd0, bif.host_done}, 64'd0);
        chk("rd_data_held", {32'd0, bif.host_rd_data}, {32'd0, exp_data});
    endtask

    initial begin
        logic [8:0] req_vec;
        logic [8:0] done_vec;
        int         done_before;

        bif.host_req     = 1'b0;
        bif.host_rd_wr_l = 1'b1;
        bif.host_addr    = '0;
        bif.host_wr_data = '0;
        model_rd         = '0;

        // Reset values and clock/reset pass-through
        repeat (2) @(negedge bus_clk);
        chk("rst_ready", {63'd0, bif.host_ready}, 64'd1);
        chk("rst_done", {63'd0, bif.host_done}, 64'd0);
        chk("rst_err", {63'd0, bif.host_err}, 64'd0);
        chk("rst_late", {63'd0, bif.late_ack}, 64'd0);
        chk("rst_rd_data", {32'd0, bif.host_rd_data}, 64'd0);
        chk("rst_req", {63'd0, bif.bus_in[BUS_FIELD_REQ]}, 64'd0);
        chk("rst_rd_wr_l", {63'd0, bif.bus_in[BUS_FIELD_RD_WR_L]}, 64'd1);
        chk("rst_addr", {48'd0, bif.bus_in[BUS_FIELD_ADDR +: BUS_ADDR_WIDTH]}, 64'd0);
        chk("rst_wr_data", {32'd0, bif.bus_in[BUS_FIELD_WR_DATA +: BUS_DATA_WIDTH]}, 64'd0);
        chk("clk_field_low", {63'd0, bif.bus_in[BUS_FIELD_CLK]}, 64'd0);
        chk("reset_field_low", {63'd0, bif.bus_in[BUS_FIELD_RESET_L]}, 64'd0);
        @(posedge bus_clk);
        #1;
        chk("clk_field_high", {63'd0, bif.bus_in[BUS_FIELD_CLK]}, 64'd1);
        @(negedge bus_clk);
        bus_reset_l = 1'b1;
        #1;
        chk("reset_field_high", {63'd0, bif.bus_in[BUS_FIELD_RESET_L]}, 64'd1);
        @(negedge bus_clk);

        // Read, write, read-back on the 1-cycle register slave
        model_rd = 32'h1234_5678;
        txn(1'b1, 16'h0010, 32'h0, 1'b0, model_rd, 2, 1'b0);
        txn(1'b0, 16'h0010, 32'hA5A5_0001, 1'b0, model_rd, 2, 1'b0);
        chk("bus_reg_written", {32'd0, bus_reg}, {32'd0, 32'hA5A5_0001});
        model_rd = 32'hA5A5_0001;
        txn(1'b1, 16'h0010, 32'h0, 1'b0, model_rd, 2, 1'b0);

        // Unmapped address: read and write both time out after 8 WAIT edges
        model_rd = 32'hDEAD_BEEF;
        txn(1'b1, 16'h03FF, 32'h0, 1'b1, model_rd, TB_TIMEOUT + 1, 1'b0);
        txn(1'b0, 16'h03FF, 32'h1111_2222, 1'b1, model_rd, TB_TIMEOUT + 1, 1'b0);

        // Ack on the final WAIT edge wins; one edge later is a timeout + late_ack
        model_rd = 32'hCAFE_0020;
        txn(1'b1, 16'h0020, 32'h0, 1'b0, model_rd, TB_TIMEOUT + 1, 1'b0);
        model_rd = 32'hDEAD_BEEF;
        txn(1'b1, 16'h0024, 32'h0, 1'b1, model_rd, TB_TIMEOUT + 1, 1'b1);

        // host_req held high: one accepted transaction every 3 cycles
        model_rd = 32'hA5A5_0001;
        repeat (3) begin
            sb_q.push_back('{err: 1'b0, data: model_rd});
            exp_done++;
        end
        bif.host_req     = 1'b1;
        bif.host_rd_wr_l = 1'b1;
        bif.host_addr    = 16'h0010;
        for (int i = 0; i < 9; i++) begin
            @(negedge bus_clk);
            req_vec[i]  = bif.bus_in[BUS_FIELD_REQ];
            done_vec[i] = bif.host_done;
        end
        bif.host_req = 1'b0;
        chk("b2b_req_pattern", {55'd0, req_vec}, {55'd0, 9'b001_001_001});
        chk("b2b_done_pattern", {55'd0, done_vec}, {55'd0, 9'b100_100_100});
        @(negedge bus_clk);
        chk("b2b_sb_empty", 64'(sb_q.size()), 64'd0);
        chk("b2b_no_extra_req", {63'd0, bif.bus_in[BUS_FIELD_REQ]}, 64'd0);

        // Asynchronous reset in the middle of WAIT aborts without host_done
        bif.host_req     = 1'b1;
        bif.host_rd_wr_l = 1'b1;
        bif.host_addr    = 16'h03FF;
        @(negedge bus_clk);
        bif.host_req = 1'b0;
        repeat (3) @(negedge bus_clk);
        chk("pre_abort_busy", {63'd0, bif.host_ready}, 64'd0);
        done_before = done_cnt;
        #2;
        bus_reset_l = 1'b0;
        #1;
        chk("abort_ready", {63'd0, bif.host_ready}, 64'd1);
        chk("abort_req", {63'd0, bif.bus_in[BUS_FIELD_REQ]}, 64'd0);
        chk("abort_done", {63'd0, bif.host_done}, 64'd0);
        chk("abort_rd_data", {32'd0, bif.host_rd_data}, 64'd0);
        chk("abort_addr", {48'd0, bif.bus_in[BUS_FIELD_ADDR +: BUS_ADDR_WIDTH]}, 64'd0);
        @(negedge bus_clk);
        bus_reset_l = 1'b1;
        repeat (12) @(negedge bus_clk);
        chk("no_done_after_abort", 64'(done_cnt), 64'(done_before));
        model_rd = 32'hA5A5_0001;
        txn(1'b1, 16'h0010, 32'h0, 1'b0, model_rd, 2, 1'b0);

        repeat (2) @(negedge bus_clk);
        chk("late_ack_total", 64'(late_cnt), 64'd1);
        chk("done_total", 64'(done_cnt), 64'(exp_done));
        chk("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    // Guard against a hung run
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/bus_master.md
Name: bus_master

Overview:
- Upstream stage of the register bus: the single bus master that drives bus_in for all bus slaves (registers, RAM windows, etc.) and consumes the OR-combined bus_out returns.
- Accepts one host transaction at a time (from a UART/JTAG/CPU bridge) and issues a one-cycle bus_req.
- Waits for bus ack, captures read data, and returns a completion or timeout to the host.

Parameters:
- TIMEOUT, 256: maximum WAIT cycles before error (2..65535).
- ERR_DATA, 32'hDEAD_BEEF: value on host_rd_data after a timed-out read (truncated to BUS_DATA_WIDTH).
- Widths BUS_IN_WIDTH, BUS_OUT_WIDTH, BUS_ADDR_WIDTH, BUS_DATA_WIDTH and field positions come from bus_params.v; they are not overridden here.

Ports:
- bus_clk  in  1  the one clock for the block and the bus.
- bus_reset_l  in  1  reset, asynchronous assert, active-low.
- bus_in  out  BUS_IN_WIDTH  bus to slaves: clk, reset_l, req, rd_wr_l, addr, wr_data fields.
- bus_out  in  BUS_OUT_WIDTH  OR of all slave returns: data field plus ack (BUS_FIELD_ACK).
- host_req  in  1  host transaction request; accepted on a rising edge where host_ready=1.
- host_rd_wr_l  in  1  1 = read, 0 = write.
- host_addr  in  BUS_ADDR_WIDTH  target address.
- host_wr_data  in  BUS_DATA_WIDTH  write data.
- host_ready  out  1  master idle and able to accept.
- host_done  out  1  one-cycle completion pulse.
- host_err  out  1  valid with host_done; 1 = timeout.
- host_rd_data  out  BUS_DATA_WIDTH  read data; valid with host_done and held until the next host_done.
- late_ack  out  1  one-cycle pulse when an ack arrives while the master is not in WAIT.

Behaviour:
- Clock and reset pass-through: bus_in clk field = bus_clk and reset_l field = bus_reset_l, both combinational.
- All other outputs are registered.
- Reset values:
  - state = IDLE, host_ready = 1.
  - host_done, host_err, late_ack = 0.
  - host_rd_data = 0.
  - bus req = 0, rd_wr_l = 1, addr = 0, wr_data = 0.
  - Timeout counter = 0.
- IDLE:
  - Edge with host_req=1 latches rd_wr_l, addr and wr_data onto the bus fields, drives req=1 and host_ready=0, and moves to REQ.
  - host_req while host_ready=0 is ignored and not queued.
- REQ:
  - Lasts exactly one cycle; req drops to 0 at the next edge; counter cleared; moves to WAIT.
  - Addr, wr_data and rd_wr_l are held stable through REQ and WAIT.
- WAIT:
  - Each edge samples bus_out ack.
  - Ack=1: host_rd_data = bus data field for reads, unchanged for writes; host_err=0; host_done=1 for one cycle; host_ready=1; go to IDLE.
  - Ack=0 with counter = TIMEOUT-1: host_err=1; host_rd_data = ERR_DATA for reads, unchanged for writes; host_done=1; host_ready=1; go to IDLE.
  - Otherwise the counter increments.
  - Ack on the final WAIT edge wins over timeout.
- Latency with a 1-cycle-ack slave: host_req sampled at edge E0, bus req high E0..E1, ack sampled at E2, host_done high E2..E3.
- Back-to-back: a new host_req may be accepted at the edge immediately after host_done, i.e. one transaction per 3 cycles minimum.
- Ack in IDLE or REQ: ignored for data; late_ack pulses one cycle. Covers a slave answering after a timeout.
- Async reset mid-transaction: all state returns to reset values immediately; no host_done is issued for the aborted transaction.
- Counter width is clog2(TIMEOUT); no wrap is possible because WAIT exits at TIMEOUT-1.

Decomposition:
- Bus field offsets and widths stay in the shared bus_params.v / bus_decl.v include pair.
- Add a BUS_TIMEOUT_DEFAULT constant there so bridges agree on the default.
- State encoding (IDLE/REQ/WAIT) stays local localparams.
- No sub-module: the timeout counter is inline.

Test Plan:
- Read of bus_reg at ADDR=0x10 returning in=0x1234_5678 -> bus req high exactly 1 cycle; host_done 2 cycles after req; host_rd_data=0x1234_5678; host_err=0.
- Write 0xA5A5_0001 to 0x10 -> bus_reg out=0xA5A5_0001 one cycle after req; host_done with host_err=0; host_rd_data unchanged.
- Read of unmapped 0x3FF with TIMEOUT=8 -> host_done exactly 8 WAIT cycles after REQ; host_err=1; host_rd_data=0xDEAD_BEEF.
- Slave acking on the 8th WAIT cycle with TIMEOUT=8 -> host_err=0 and data captured; a slave acking on the 9th -> timeout plus late_ack pulse one cycle after host_done.
- host_req held high continuously -> transactions at a 3-cycle cadence; host_req while busy is not issued twice.
- bus_reset_l asserted during WAIT -> host_ready=1, req=0, host_done=0 immediately; after release, the next read completes normally.
